// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared definitions for the ALU/MDU slice.
//   ALU_OP_W     : opcode width
//   op_e         : full opcode map (base ALU with op[4]=0, MDU with op[4]=1)
//   state_e      : controller states
//   mdu_a_signed / mdu_b_signed : operand signedness for an MDU sub-op op[2:0]
package alu_mdu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_SUB    = 5'b01000,
        OP_SRA    = 5'b01101,
        // MDU ops decode on op[2:0] only; op[3] is a don't-care
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Signed first operand: MUL, MULH, MULHSU, DIV, REM
    function automatic logic mdu_a_signed(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b110);
    endfunction

    // Signed second operand: MUL, MULH, DIV, REM
    function automatic logic mdu_b_signed(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Operands are converted to magnitudes at start; the sign is restored on the
// final step so the result is valid in the same cycle that done is high.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : load operands and begin XLEN iterations
//   is_div            : 1 = divide, 0 = multiply
//   a_signed/b_signed : operand signedness
//   src_a, src_b      : operands (dividend/divisor for divide)
//   done              : high during the last iteration cycle; result valid
//   result            : product (2*XLEN) or {remainder, quotient}
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic              done,
    output logic [2*XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic              running;
    logic [CW-1:0]     cnt;
    logic              div_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     sub_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign a_neg    = a_signed && src_a[XLEN-1];
    assign b_neg    = b_signed && src_b[XLEN-1];
    assign mag_a_in = a_neg ? -src_a : src_a;
    assign mag_b_in = b_neg ? -src_b : src_b;

    // acc holds {high, low}. Multiply: high accumulates, low is the multiplier
    // shifting out LSB-first. Divide: high is the partial remainder, low is the
    // dividend shifting out MSB-first while quotient bits shift in.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        sub_diff = shifted - {1'b0, mag_b};
        if (div_q) begin
            // partial remainder < 2*divisor, so bit XLEN of the difference is the borrow
            if (sub_diff[XLEN]) begin
                acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        quot = acc_next[XLEN-1:0];
        rem  = acc_next[2*XLEN-1:XLEN];
        if (div_q) begin
            // quotient truncates toward zero; remainder takes the dividend's sign
            result = {(rem_neg_q ? -rem : rem), (neg_q ? -quot : quot)};
        end else begin
            result = neg_q ? -acc_next : acc_next;
        end
    end

    assign done = running && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            running   <= 1'b0;
            cnt       <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mag_b     <= '0;
            acc       <= '0;
        end else if (start) begin
            running   <= 1'b1;
            cnt       <= '0;
            div_q     <= is_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            mag_b     <= mag_b_in;
            acc       <= {{XLEN{1'b0}}, mag_a_in};
        end else if (running) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: RV-style base ALU with optional iterative multiply/divide unit.
// Base ops return one cycle after acceptance; iterative MDU ops return
// XLEN+1 cycles after acceptance. Divide-by-zero and signed overflow are
// resolved in one cycle without starting the iterator.
// Build option: define ALU_MDU_MDU_EN to include the MDU datapath. Without it,
// MDU opcodes complete in one cycle with result 0 and busy is tied low.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : request handshake
//   op, inv, src_a, src_b  : opcode, branch-flag invert, operands
//   out_valid / out_ready  : result handshake
//   result, branch_flag    : registered outputs, held while stalled
//   busy                   : iterative MDU op in flight
//
// state   | meaning
// IDLE    | accepting requests (subject to output backpressure)
// MUL     | multiply iterating, one bit per cycle
// DIV     | divide iterating, one bit per cycle
// DONE    | MDU result presented, waiting for output transfer
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic                inv,
    input  logic [XLEN-1:0]     src_a,
    input  logic [XLEN-1:0]     src_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                branch_flag,
    output logic                busy
);

    state_e          state_q;
    state_e          state_d;
    logic            accept;
    logic            out_xfer;
    logic            mdu_start;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_res;
    logic [XLEN-1:0] mdu_fast_res;
    logic [XLEN-1:0] alu_res;
    logic            alu_flag;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;

    assign out_xfer = out_valid && out_ready;
    assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Base ALU
    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign shamt = src_b[SHW-1:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        if (!op[4]) begin
            case (op)
                OP_ADD:  alu_res = sum;
                OP_SUB: begin
                    alu_res  = diff;
                    alu_flag = inv ^ (diff == '0);
                end
                OP_SLL:  alu_res = src_a << shamt;
                OP_SLT: begin
                    alu_res  = {{(XLEN-1){1'b0}}, lt_s};
                    alu_flag = inv ^ lt_s;
                end
                OP_SLTU: begin
                    alu_res  = {{(XLEN-1){1'b0}}, lt_u};
                    alu_flag = inv ^ lt_u;
                end
                OP_XOR:  alu_res = src_a ^ src_b;
                OP_SRL:  alu_res = src_a >> shamt;
                OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
                OP_OR:   alu_res = src_a | src_b;
                OP_AND:  alu_res = src_a & src_b;
                default: alu_res = '0;
            endcase
        end
    end

`ifdef ALU_MDU_MDU_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        mdu_f;
    logic [2:0]        mdu_f_q;
    logic              div_zero;
    logic              div_ovf;
    logic              mdu_fast;
    logic              sel_high;
    logic [2*XLEN-1:0] mdu_full;

    assign mdu_f    = op[2:0];
    assign div_zero = (src_b == '0);
    // signed overflow only applies to DIV/REM (op[0]=0 among the divides)
    assign div_ovf  = (src_a == MOST_NEG) && (src_b == '1) && !mdu_f[0];
    assign mdu_fast = mdu_f[2] && (div_zero || div_ovf);

    always_comb begin
        if (div_zero) begin
            mdu_fast_res = mdu_f[1] ? src_a : '1;
        end else begin
            mdu_fast_res = mdu_f[1] ? '0 : src_a;
        end
    end

    assign mdu_start = accept && op[4] && !mdu_fast;

    mdu_iter #(
        .XLEN(XLEN)
    ) u_mdu_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (mdu_start),
        .is_div  (mdu_f[2]),
        .a_signed(mdu_a_signed(mdu_f)),
        .b_signed(mdu_b_signed(mdu_f)),
        .src_a   (src_a),
        .src_b   (src_b),
        .done    (mdu_done),
        .result  (mdu_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_f_q <= '0;
        end else if (mdu_start) begin
            mdu_f_q <= mdu_f;
        end
    end

    // Upper half for MULH/MULHSU/MULHU and for the remainder ops
    assign sel_high = mdu_f_q[2] ? mdu_f_q[1] : (mdu_f_q[1:0] != 2'b00);
    assign mdu_res  = sel_high ? mdu_full[2*XLEN-1:XLEN] : mdu_full[XLEN-1:0];
    assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
`else
    assign mdu_start    = 1'b0;
    assign mdu_done     = 1'b0;
    assign mdu_res      = '0;
    assign mdu_fast_res = '0;
    assign busy         = 1'b0;
`endif

    // Controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu_start) begin
                    state_d = op[2] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdu_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: an accepted iterative op clears out_valid through the
    // transfer branch, since acceptance implies any pending result transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result      <= '0;
            branch_flag <= 1'b0;
        end else if (accept && !mdu_start) begin
            out_valid   <= 1'b1;
            result      <= op[4] ? mdu_fast_res : alu_res;
            branch_flag <= op[4] ? 1'b0 : alu_flag;
        end else if (mdu_done) begin
            out_valid   <= 1'b1;
            result      <= mdu_res;
            branch_flag <= 1'b0;
        end else if (out_xfer) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

    localparam int XLEN = 32;
`ifdef ALU_MDU_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic            inv;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_flag;
    logic            busy;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .inv        (inv),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .branch_flag(branch_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] res;
        logic        flag;
        int          acc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    bit   fresh = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic iv);
        logic [31:0] r;
        logic        f;
`ifdef ALU_MDU_MDU_EN
        logic [63:0]        sa, sbx, ua, ub, p;
        logic signed [31:0] qa, qb;
        sa  = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        qa  = a;
        qb  = b;
        p   = '0;
`endif
        r = '0;
        f = 1'b0;
        if (!o[4]) begin
            case (o)
                5'b00000: r = a + b;
                5'b01000: begin r = a - b; f = iv ^ (r == 32'h0); end
                5'b00001: r = a << b[4:0];
                5'b00010: begin r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0; f = iv ^ r[0]; end
                5'b00011: begin r = (a < b) ? 32'h1 : 32'h0; f = iv ^ r[0]; end
                5'b00100: r = a ^ b;
                5'b00101: r = a >> b[4:0];
                5'b01101: r = $unsigned($signed(a) >>> b[4:0]);
                5'b00110: r = a | b;
                5'b00111: r = a & b;
                default:  r = '0;
            endcase
        end else begin
`ifdef ALU_MDU_MDU_EN
            case (o[2:0])
                3'd0: begin p = sa * sbx; r = p[31:0];  end
                3'd1: begin p = sa * sbx; r = p[63:32]; end
                3'd2: begin p = sa * ub;  r = p[63:32]; end
                3'd3: begin p = ua * ub;  r = p[63:32]; end
                3'd4: begin
                    if (b == 32'h0) r = 32'hffffffff;
                    else if (a == 32'h80000000 && b == 32'hffffffff) r = a;
                    else r = qa / qb;
                end
                3'd5: begin
                    if (b == 32'h0) r = 32'hffffffff;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 32'h0) r = a;
                    else if (a == 32'h80000000 && b == 32'hffffffff) r = 32'h0;
                    else r = qa % qb;
                end
                default: begin
                    if (b == 32'h0) r = a;
                    else r = a % b;
                end
            endcase
`endif
        end
        return {f, r};
    endfunction

    function automatic int latency(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        fast = o[2] && ((b == 32'h0) || (!o[0] && a == 32'h80000000 && b == 32'hffffffff));
        if (o[4] && MDU_EN && !fast) return XLEN + 1;
        return 1;
    endfunction

    task automatic push(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic iv);
        exp_t        e;
        logic [32:0] m;
        m     = model(o, a, b, iv);
        e.res = m[31:0];
        e.flag = m[32];
        e.acc = cyc;
        e.lat = latency(o, a, b);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic iv);
        int n = 0;
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        inv      = iv;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 64'(in_ready), 64'd1);
        if (in_ready) push(tag, o, a, b, iv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: checks latency when a result first appears, data on transfer.
    always @(negedge clk) begin
        if (rst) begin
            fresh = 1'b1;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                if (fresh) begin
                    check({exp_q[0].tag, "_latency"}, 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    fresh = 1'b0;
                end
                if (out_ready) begin
                    check({exp_q[0].tag, "_result"}, 64'(result), 64'(exp_q[0].res));
                    check({exp_q[0].tag, "_flag"}, 64'(branch_flag), 64'(exp_q[0].flag));
                    void'(exp_q.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bc;
        int c0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        inv       = 1'b0;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flag", 64'(branch_flag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send("add_ovf", 5'b00000, 32'h7fffffff, 32'h1, 1'b0);
        drain("add_ovf");

        // back-to-back base ops, one per cycle
        c0 = cyc;
        send("sub_eq_inv", 5'b01000, 32'd5, 32'd5, 1'b1);
        send("sub_eq", 5'b01000, 32'd5, 32'd5, 1'b0);
        send("sub_ne", 5'b01000, 32'd9, 32'd5, 1'b0);
        send("slt", 5'b00010, 32'hffffffff, 32'h1, 1'b0);
        send("sltu_inv", 5'b00011, 32'hffffffff, 32'h1, 1'b1);
        send("sll", 5'b00001, 32'h1, 32'd33, 1'b0);
        send("srl", 5'b00101, 32'h80000000, 32'd4, 1'b0);
        send("sra", 5'b01101, 32'h80000000, 32'd4, 1'b0);
        send("xor", 5'b00100, 32'ha5a5a5a5, 32'hffff0000, 1'b0);
        send("or", 5'b00110, 32'h0000f0f0, 32'h00000f0f, 1'b0);
        send("and", 5'b00111, 32'hff00ff00, 32'h0ff00ff0, 1'b0);
        send("undef", 5'b01001, 32'h12345678, 32'h1, 1'b1);
        check("b2b_cycles", 64'(cyc - c0), 64'd12);
        drain("b2b");

        // MULH with operands changed after acceptance
        send("mulh_min", 5'b10001, 32'h80000000, 32'h80000000, 1'b0);
        src_a = 32'h12345678;
        src_b = 32'h0;
        op    = 5'b00000;
        n  = 0;
        bc = 0;
        while (n < 100) begin
            @(negedge clk);
            if (busy) bc++;
            if (out_valid) break;
            n++;
        end
        check("mulh_busy_cycles", 64'(bc), MDU_EN ? 64'd32 : 64'd0);
        @(posedge clk);
        #1;
        drain("mulh_min");

        send("mul_neg", 5'b10000, 32'd7, 32'hfffffffd, 1'b0);            drain("mul_neg");
        send("mulhsu", 5'b10010, 32'hffffffff, 32'd2, 1'b0);             drain("mulhsu");
        send("mulhu", 5'b10011, 32'hffffffff, 32'hffffffff, 1'b0);       drain("mulhu");
        send("mulh_m1", 5'b11001, 32'hffffffff, 32'hffffffff, 1'b0);     drain("mulh_m1");
        send("div_ovf", 5'b10100, 32'h80000000, 32'hffffffff, 1'b1);     drain("div_ovf");
        send("divu_zero", 5'b10101, 32'd7, 32'd0, 1'b0);                 drain("divu_zero");
        send("rem_neg", 5'b10110, 32'hfffffff9, 32'd2, 1'b0);            drain("rem_neg");
        send("div_neg", 5'b10100, 32'hfffffff9, 32'd2, 1'b0);            drain("div_neg");
        send("remu_zero", 5'b10111, 32'd100, 32'd0, 1'b0);               drain("remu_zero");
        send("rem_ovf", 5'b10110, 32'h80000000, 32'hffffffff, 1'b0);     drain("rem_ovf");
        send("divu_big", 5'b10101, 32'hffffffff, 32'd3, 1'b0);           drain("divu_big");
        send("remu", 5'b10111, 32'd100, 32'd7, 1'b0);                    drain("remu");
        send("div_negb", 5'b10100, 32'd100, 32'hfffffff9, 1'b0);         drain("div_negb");

        // output backpressure with a queued request
        out_ready = 1'b0;
        send("stall_add", 5'b00000, 32'd10, 32'd20, 1'b0);
        in_valid = 1'b1;
        op       = 5'b00100;
        src_a    = 32'h000000f0;
        src_b    = 32'h0000000f;
        inv      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(result), 64'd30);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) push("queued_xor", 5'b00100, 32'h000000f0, 32'h0000000f, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("stall");

        // reset in the middle of a divide, with a request on the same cycle
        send("div_abort", 5'b10100, 32'd1000, 32'd7, 1'b0);
`ifdef ALU_MDU_MDU_EN
        exp_q.delete();
`endif
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 5'b00000;
        src_a    = 32'd1;
        src_b    = 32'd2;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flag", 64'(branch_flag), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        repeat (40) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("abort_queue", 64'(exp_q.size()), 64'd0);

        send("post_rst_add", 5'b00000, 32'hffffffff, 32'h1, 1'b0);
        drain("post_rst_add");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
